// File: rtl/iir_pkg.sv
// Shared types and constants for the fixed-point IIR datapath.
// Formats: samples sfix22_En14, coefficients sfix18_En16, accumulator sfix44_En30.
package iir_pkg;

  typedef logic signed [21:0] sample_t;
  typedef logic signed [17:0] coef_t;
  typedef logic signed [43:0] acc_t;

  localparam acc_t        ROUND_BIAS = 44'sd32768;
  localparam int unsigned SHIFT      = 16;
  localparam acc_t        Y_MAX      = 44'sd2097151;
  localparam acc_t        Y_MIN      = -44'sd2097152;

  typedef enum logic [1:0] {StIdle, StMac, StRound, StOut} state_e;

endpackage

// File: rtl/iir_round_sat.sv
// Requantises an En30 accumulator to an En14 sample.
// Rounds half toward +inf, then saturates; sat flags a clipped result.
module iir_round_sat
  import iir_pkg::*;
(
  input  acc_t    acc,
  output sample_t y,
  output logic    sat
);

  acc_t shifted;

  always_comb begin
    shifted = (acc + ROUND_BIAS) >>> SHIFT;
    y       = shifted[21:0];
    sat     = 1'b0;
    if (shifted > Y_MAX) begin
      y   = Y_MAX[21:0];
      sat = 1'b1;
    end else if (shifted < Y_MIN) begin
      y   = Y_MIN[21:0];
      sat = 1'b1;
    end
  end

endmodule

// File: rtl/iir_biquad_mac_seq.sv
// Direct-form-I biquad sharing one multiplier over five products per sample.
// Flow: accept -> 5 MAC cycles -> round/saturate -> hold output until taken.
module iir_biquad_mac_seq
  import iir_pkg::*;
#(
  parameter int unsigned DW = 22,
  parameter int unsigned CW = 18,
  parameter int unsigned AW = 44
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic signed [DW-1:0] in_data,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic signed [CW-1:0] coef_b0,
  input  logic signed [CW-1:0] coef_b1,
  input  logic signed [CW-1:0] coef_b2,
  input  logic signed [CW-1:0] coef_a1,
  input  logic signed [CW-1:0] coef_a2,
  input  logic                 clr_state,
  output logic signed [DW-1:0] out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 sat_flag
);

  state_e state_q, state_d;
  logic [2:0] k_q, k_d;
  logic signed [AW-1:0] acc_q, acc_d;
  logic signed [DW-1:0] x_q, x_d, x1_q, x1_d, x2_q, x2_d, y1_q, y1_d, y2_q, y2_d;
  logic signed [CW-1:0] b0_q, b0_d, b1_q, b1_d, b2_q, b2_d, a1_q, a1_d, a2_q, a2_d;
  logic signed [DW-1:0] out_data_q, out_data_d;
  logic out_valid_q, out_valid_d, sat_q, sat_d;

  logic signed [DW-1:0]    mul_x;
  logic signed [CW-1:0]    mul_c;
  logic signed [DW+CW-1:0] prod;
  logic signed [AW-1:0]    term;
  sample_t                 y_q;
  logic                    y_sat;

  iir_round_sat u_round_sat (
    .acc (acc_q),
    .y   (y_q),
    .sat (y_sat)
  );

  // Operand select for the shared multiplier, indexed by the MAC step.
  always_comb begin
    mul_x = '0;
    mul_c = '0;
    case (k_q)
      3'd0: begin mul_x = x_q;  mul_c = b0_q; end
      3'd1: begin mul_x = x1_q; mul_c = b1_q; end
      3'd2: begin mul_x = x2_q; mul_c = b2_q; end
      3'd3: begin mul_x = y1_q; mul_c = a1_q; end
      3'd4: begin mul_x = y2_q; mul_c = a2_q; end
      default: ;
    endcase
    prod = (DW+CW)'(mul_x) * (DW+CW)'(mul_c);
    term = AW'(prod);
  end

  always_comb begin
    state_d     = state_q;
    k_d         = k_q;
    acc_d       = acc_q;
    x_d         = x_q;
    x1_d        = x1_q;
    x2_d        = x2_q;
    y1_d        = y1_q;
    y2_d        = y2_q;
    b0_d        = b0_q;
    b1_d        = b1_q;
    b2_d        = b2_q;
    a1_d        = a1_q;
    a2_d        = a2_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    sat_d       = sat_q;
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          x_d     = in_data;
          b0_d    = coef_b0;
          b1_d    = coef_b1;
          b2_d    = coef_b2;
          a1_d    = coef_a1;
          a2_d    = coef_a2;
          acc_d   = '0;
          k_d     = '0;
          state_d = StMac;
        end
        // Clearing here also covers a sample accepted on this same edge.
        if (clr_state) begin
          x1_d = '0;
          x2_d = '0;
          y1_d = '0;
          y2_d = '0;
        end
      end
      StMac: begin
        acc_d = (k_q >= 3'd3) ? acc_q - term : acc_q + term;
        k_d   = k_q + 3'd1;
        if (k_q == 3'd4) state_d = StRound;
      end
      StRound: begin
        out_data_d  = y_q;
        out_valid_d = 1'b1;
        sat_d       = sat_q | y_sat;
        x2_d        = x1_q;
        x1_d        = x_q;
        y2_d        = y1_q;
        y1_d        = y_q;
        state_d     = StOut;
      end
      StOut: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = StIdle;
        end
        if (clr_state) begin
          x1_d = '0;
          x2_d = '0;
          y1_d = '0;
          y2_d = '0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= StIdle;
      k_q         <= '0;
      acc_q       <= '0;
      x_q         <= '0;
      x1_q        <= '0;
      x2_q        <= '0;
      y1_q        <= '0;
      y2_q        <= '0;
      b0_q        <= '0;
      b1_q        <= '0;
      b2_q        <= '0;
      a1_q        <= '0;
      a2_q        <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      sat_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      k_q         <= k_d;
      acc_q       <= acc_d;
      x_q         <= x_d;
      x1_q        <= x1_d;
      x2_q        <= x2_d;
      y1_q        <= y1_d;
      y2_q        <= y2_d;
      b0_q        <= b0_d;
      b1_q        <= b1_d;
      b2_q        <= b2_d;
      a1_q        <= a1_d;
      a2_q        <= a2_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      sat_q       <= sat_d;
    end
  end

  assign in_ready  = reset_n && (state_q == StIdle);
  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign sat_flag  = sat_q;

endmodule

// File: tb/tb_iir_biquad_mac_seq.sv
// Self-checking bench: directed cases plus randomized samples against a
// plain-arithmetic biquad reference model.
module tb_iir_biquad_mac_seq;
  import iir_pkg::*;

  logic    clk = 1'b0;
  logic    reset_n;
  sample_t in_data;
  logic    in_valid;
  logic    in_ready;
  coef_t   b0, b1, b2, a1, a2;
  logic    clr_state;
  sample_t out_data;
  logic    out_valid;
  logic    out_ready;
  logic    sat_flag;

  int vectors = 0;
  int miscompares = 0;

  // Reference model state
  longint mx1, mx2, my1, my2;
  bit     msat;
  longint expq[$];

  iir_biquad_mac_seq dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .coef_b0   (b0),
    .coef_b1   (b1),
    .coef_b2   (b2),
    .coef_a1   (a1),
    .coef_a2   (a2),
    .clr_state (clr_state),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sat_flag  (sat_flag)
  );

  always #5 clk = ~clk;

  initial begin
    #800000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic check(input string tag, input longint obs, input longint exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    mx1 = 0; mx2 = 0; my1 = 0; my2 = 0;
  endtask

  // y = b0*x + b1*x1 + b2*x2 - a1*y1 - a2*y2, round half up at 2^-14, clip to 22 bits
  task automatic model_step(input longint x, output longint y);
    longint acc;
    acc = longint'(b0) * x + longint'(b1) * mx1 + longint'(b2) * mx2
        - longint'(a1) * my1 - longint'(a2) * my2;
    y = (acc + 32768) >>> 16;
    if (y > 2097151) begin
      y = 2097151;
      msat = 1'b1;
    end else if (y < -2097152) begin
      y = -2097152;
      msat = 1'b1;
    end
    mx2 = mx1; mx1 = x; my2 = my1; my1 = y;
  endtask

  task automatic set_coefs(input longint c0, input longint c1, input longint c2,
                           input longint c3, input longint c4);
    b0 = coef_t'(c0); b1 = coef_t'(c1); b2 = coef_t'(c2); a1 = coef_t'(c3); a2 = coef_t'(c4);
  endtask

  task automatic send(input longint x, input bit clr);
    int n;
    longint y;
    in_data = sample_t'(x);
    in_valid = 1'b1;
    clr_state = clr;
    n = 0;
    while (!in_ready && n < 64) begin
      @(posedge clk); #1; n++;
    end
    check("in_ready_wait", longint'(in_ready), 1);
    @(posedge clk);
    if (clr) model_clear();
    model_step(x, y);
    expq.push_back(y);
    #1;
    in_valid = 1'b0;
    clr_state = 1'b0;
  endtask

  task automatic recv(input int bp, input bit chk_lat, output longint y);
    int e;
    longint hold, exp;
    e = 0;
    while (!out_valid && e < 64) begin
      @(posedge clk); #1; e++;
    end
    check("out_valid_seen", longint'(out_valid), 1);
    if (chk_lat) check("latency", longint'(e), 6);
    hold = longint'(out_data);
    for (int i = 0; i < bp; i++) begin
      @(posedge clk); #1;
      check("bp_stable", longint'(out_data), hold);
      check("bp_valid", longint'(out_valid), 1);
      check("bp_in_ready", longint'(in_ready), 0);
    end
    y = longint'(out_data);
    exp = (expq.size() > 0) ? expq.pop_front() : -9999999;
    check("out_data", y, exp);
    check("sat_flag", longint'(sat_flag), longint'(msat));
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("out_valid_drop", longint'(out_valid), 0);
  endtask

  initial begin
    longint y, pend;
    reset_n = 1'b0; in_valid = 1'b0; in_data = '0; clr_state = 1'b0; out_ready = 1'b0;
    set_coefs(0, 0, 0, 0, 0);
    model_clear(); msat = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", longint'(in_ready), 0);
    check("rst_out_valid", longint'(out_valid), 0);
    check("rst_out_data", longint'(out_data), 0);
    check("rst_sat_flag", longint'(sat_flag), 0);
    reset_n = 1'b1;
    @(posedge clk); #1;
    check("idle_in_ready", longint'(in_ready), 1);

    // Pass-through
    set_coefs(65536, 0, 0, 0, 0);
    send(16384, 0);
    recv(0, 1, y);
    check("pass_const", y, 16384);

    // Recursive impulse response
    set_coefs(65536, 0, 0, -32768, 0);
    send(16384, 1); recv(0, 1, y); check("imp0_const", y, 16384);
    send(0, 0);     recv(0, 1, y); check("imp1_const", y, 8192);
    send(0, 0);     recv(0, 1, y); check("imp2_const", y, 4096);

    // Rounding
    set_coefs(32768, 0, 0, 0, 0);
    send(-3, 1); recv(0, 1, y); check("round_neg_const", y, -1);
    send(3, 0);  recv(0, 1, y); check("round_half_const", y, 2);

    // Saturation
    check("sat_before", longint'(sat_flag), 0);
    set_coefs(131071, 0, 0, 0, 0);
    send(2097151, 1);  recv(0, 1, y); check("sat_pos_const", y, 2097151);
    check("sat_set", longint'(sat_flag), 1);
    send(-2097152, 1); recv(0, 1, y); check("sat_neg_const", y, -2097152);

    // Backpressure with a pending input sample
    set_coefs(65536, 0, 0, 0, 0);
    send(1000, 1);
    in_data = sample_t'(2000);
    in_valid = 1'b1;
    recv(10, 1, y);
    check("bp_first_const", y, 1000);
    check("bp_ready_after_hs", longint'(in_ready), 1);
    @(posedge clk);
    model_step(2000, pend);
    expq.push_back(pend);
    #1;
    in_valid = 1'b0;
    check("bp_accepted", longint'(in_ready), 0);
    recv(0, 1, y);
    check("bp_second_const", y, 2000);

    // Randomized samples, coefficients scrambled while in flight
    for (int it = 0; it < 40; it++) begin
      set_coefs(longint'($urandom_range(0, 65535)) - 32768,
                longint'($urandom_range(0, 65535)) - 32768,
                longint'($urandom_range(0, 65535)) - 32768,
                longint'($urandom_range(0, 65535)) - 32768,
                longint'($urandom_range(0, 65535)) - 32768);
      send(longint'($urandom_range(0, 524287)) - 262144, ($urandom_range(0, 7) == 0));
      set_coefs(longint'($urandom_range(0, 262143)) - 131072, 0, 0,
                longint'($urandom_range(0, 262143)) - 131072, 0);
      recv(int'($urandom_range(0, 3)), 1, y);
      if ($urandom_range(0, 5) == 0) begin
        clr_state = 1'b1;
        @(posedge clk); #1;
        clr_state = 1'b0;
        model_clear();
      end
    end

    // Reset while the MAC is at k=2
    set_coefs(65536, 0, 0, -32768, 0);
    send(5000, 0);
    @(posedge clk);
    @(posedge clk); #1;
    reset_n = 1'b0;
    #1;
    check("mid_rst_out_valid", longint'(out_valid), 0);
    check("mid_rst_out_data", longint'(out_data), 0);
    check("mid_rst_sat_flag", longint'(sat_flag), 0);
    check("mid_rst_in_ready", longint'(in_ready), 0);
    expq.delete();
    model_clear();
    msat = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #1;
    set_coefs(65536, 65536, 0, 0, 0);
    send(16384, 0);
    recv(0, 1, y);
    check("post_rst_const", y, 16384);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
